// File: rtl/axis_rx_checker.sv
// AXI4-Stream receive terminator: programmable backpressure,
// per-packet framing checks and running packet/byte/error statistics.
module axis_rx_checker #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [7:0]                        ready_pattern,
    input  logic                              clear,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       byte_count,
    output logic [15:0]                       len_err_count,
    output logic [15:0]                       strb_err_count,
    output logic [15:0]                       last_len,
    output logic [7:0]                        last_src_port,
    output logic [7:0]                        last_dst_port,
    output logic                              pkt_done,
    output logic                              in_pkt
);

    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [STRB_W-1:0] STRB_ONE = 1;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic        tready_q, tready_d;
    logic [15:0] acc_q, acc_d;
    logic        sat_q, sat_d;
    logic        serr_q, serr_d;
    logic [31:0] user_q, user_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] byte_count_q, byte_count_d;
    logic [15:0] len_err_q, len_err_d;
    logic [15:0] strb_err_q, strb_err_d;
    logic [15:0] last_len_q, last_len_d;
    logic [7:0]  last_src_q, last_src_d;
    logic [7:0]  last_dst_q, last_dst_d;
    logic        pkt_done_q, pkt_done_d;

    logic        accept;
    logic        first;
    logic [15:0] beat_bytes;
    logic [16:0] sum;
    logic [15:0] total;
    logic        last_ok;
    logic        beat_bad;
    logic [31:0] user_cur;
    logic        unused;

    // Payload and upper sideband bits are intentionally not inspected.
    assign unused = ^{s_axis_tdata, s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:32]};

    assign accept = s_axis_tvalid && tready_q;
    assign first  = (state_q == IDLE);

    // Beat byte count, running total and tstrb shape of the current beat.
    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < STRB_W; i++) begin
            beat_bytes = beat_bytes + {15'd0, s_axis_tstrb[i]};
        end
        sum      = {1'b0, (first ? 16'd0 : acc_q)} + {1'b0, beat_bytes};
        total    = sum[16] ? 16'hFFFF : sum[15:0];
        last_ok  = (|s_axis_tstrb) &&
                   ((s_axis_tstrb & (s_axis_tstrb + STRB_ONE)) == '0);
        beat_bad = s_axis_tlast ? !last_ok : !(&s_axis_tstrb);
        user_cur = first ? s_axis_tuser[31:0] : user_q;
    end

    // Next-state: pattern pointer, packet FSM, completion stats, clear.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q + 3'd1;
        tready_d     = ready_pattern[ptr_q];
        acc_d        = acc_q;
        sat_d        = sat_q;
        serr_d       = serr_q;
        user_d       = user_q;
        pkt_count_d  = pkt_count_q;
        byte_count_d = byte_count_q;
        len_err_d    = len_err_q;
        strb_err_d   = strb_err_q;
        last_len_d   = last_len_q;
        last_src_d   = last_src_q;
        last_dst_d   = last_dst_q;
        pkt_done_d   = 1'b0;

        if (accept) begin
            acc_d  = total;
            sat_d  = (first ? 1'b0 : sat_q) | sum[16];
            serr_d = (first ? 1'b0 : serr_q) | beat_bad;
            user_d = user_cur;
            if (s_axis_tlast) begin
                state_d      = IDLE;
                pkt_done_d   = 1'b1;
                pkt_count_d  = pkt_count_q + 32'd1;
                byte_count_d = byte_count_q + {16'd0, total};
                if (((total != user_cur[15:0]) || sat_d) &&
                    (len_err_q != 16'hFFFF)) begin
                    len_err_d = len_err_q + 16'd1;
                end
                if (serr_d && (strb_err_q != 16'hFFFF)) begin
                    strb_err_d = strb_err_q + 16'd1;
                end
                last_len_d = total;
                last_src_d = user_cur[23:16];
                last_dst_d = user_cur[31:24];
            end else begin
                state_d = IN_PKT;
            end
        end

        if (clear) begin
            pkt_count_d  = '0;
            byte_count_d = '0;
            len_err_d    = '0;
            strb_err_d   = '0;
            last_len_d   = '0;
            last_src_d   = '0;
            last_dst_d   = '0;
        end
    end

    // State and statistics registers.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            tready_q     <= 1'b0;
            acc_q        <= '0;
            sat_q        <= 1'b0;
            serr_q       <= 1'b0;
            user_q       <= '0;
            pkt_count_q  <= '0;
            byte_count_q <= '0;
            len_err_q    <= '0;
            strb_err_q   <= '0;
            last_len_q   <= '0;
            last_src_q   <= '0;
            last_dst_q   <= '0;
            pkt_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tready_q     <= tready_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            serr_q       <= serr_d;
            user_q       <= user_d;
            pkt_count_q  <= pkt_count_d;
            byte_count_q <= byte_count_d;
            len_err_q    <= len_err_d;
            strb_err_q   <= strb_err_d;
            last_len_q   <= last_len_d;
            last_src_q   <= last_src_d;
            last_dst_q   <= last_dst_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign pkt_count      = pkt_count_q;
    assign byte_count     = byte_count_q;
    assign len_err_count  = len_err_q;
    assign strb_err_count = strb_err_q;
    assign last_len       = last_len_q;
    assign last_src_port  = last_src_q;
    assign last_dst_port  = last_dst_q;
    assign pkt_done       = pkt_done_q;
    assign in_pkt         = (state_q == IN_PKT);

endmodule

// File: tb/tb_axis_rx_checker.sv
// Scoreboard bench for axis_rx_checker: driver feeds a packet-level
// reference model, monitor compares every pkt_done against it.
module tb_axis_rx_checker;

    logic         axi_aclk = 1'b0;
    logic         axi_resetn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [7:0]   ready_pattern;
    logic         clear;
    logic [31:0]  pkt_count, byte_count;
    logic [15:0]  len_err_count, strb_err_count, last_len;
    logic [7:0]   last_src_port, last_dst_port;
    logic         pkt_done, in_pkt;

    axis_rx_checker dut (
        .axi_aclk       (axi_aclk),
        .axi_resetn     (axi_resetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .ready_pattern  (ready_pattern),
        .clear          (clear),
        .pkt_count      (pkt_count),
        .byte_count     (byte_count),
        .len_err_count  (len_err_count),
        .strb_err_count (strb_err_count),
        .last_len       (last_len),
        .last_src_port  (last_src_port),
        .last_dst_port  (last_dst_port),
        .pkt_done       (pkt_done),
        .in_pkt         (in_pkt)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] bc;
        logic [15:0] le;
        logic [15:0] se;
        logic [15:0] ll;
        logic [7:0]  src;
        logic [7:0]  dst;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] bq[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc, m_bc;
    int          m_le, m_se;
    logic [15:0] m_ll;
    logic [7:0]  m_src, m_dst;
    int          m_sum;
    bit          m_serr;
    bit          m_first;
    logic [31:0] m_user;
    bit          exp_inpkt;
    int          mptr;
    bit          exp_rdy;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mask(input int n);
        logic [32:0] m;
        m = (33'd1 << n) - 33'd1;
        return m[31:0];
    endfunction

    // Expected tready: pattern bit for slot k appears after the k-th edge.
    always @(posedge axi_aclk) begin
        if (axi_resetn) begin
            exp_rdy = ready_pattern[mptr];
            mptr    = (mptr + 1) % 8;
        end
    end

    // Monitor: tready/in_pkt every cycle, scoreboard pop on pkt_done.
    always @(negedge axi_aclk) begin
        if (axi_resetn) begin
            chk("tready", {31'd0, s_axis_tready}, {31'd0, exp_rdy});
            chk("in_pkt", {31'd0, in_pkt}, {31'd0, exp_inpkt});
            if (pkt_done) begin
                if (sbq.size() == 0) begin
                    chk("pkt_done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("pkt_count", pkt_count, e.pc);
                    chk("byte_count", byte_count, e.bc);
                    chk("len_err", {16'd0, len_err_count}, {16'd0, e.le});
                    chk("strb_err", {16'd0, strb_err_count}, {16'd0, e.se});
                    chk("last_len", {16'd0, last_len}, {16'd0, e.ll});
                    chk("last_src", {24'd0, last_src_port}, {24'd0, e.src});
                    chk("last_dst", {24'd0, last_dst_port}, {24'd0, e.dst});
                end
            end
        end
    end

    task automatic model_clear();
        m_pc = 0; m_bc = 0; m_le = 0; m_se = 0;
        m_ll = 0; m_src = 0; m_dst = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pc"}, pkt_count, 32'd0);
        chk({tag, "_bc"}, byte_count, 32'd0);
        chk({tag, "_le"}, {16'd0, len_err_count}, 32'd0);
        chk({tag, "_se"}, {16'd0, strb_err_count}, 32'd0);
        chk({tag, "_ll"}, {16'd0, last_len}, 32'd0);
        chk({tag, "_ports"}, {16'd0, last_src_port, last_dst_port}, 32'd0);
    endtask

    // Packet-level rules applied to one accepted beat; returns completion.
    task automatic model_beat(input logic [31:0] strb, input bit last,
                              input logic [31:0] user, output bit done);
        int n;
        int tot;
        bit ok;
        done = 0;
        if (m_first) begin
            m_sum  = 0;
            m_serr = 0;
            m_user = user;
        end
        n = $countones(strb);
        m_sum += n;
        if (last) ok = (n > 0) && (strb == mask(n));
        else      ok = (strb == 32'hFFFF_FFFF);
        if (!ok) m_serr = 1;
        m_first   = last;
        exp_inpkt = !last;
        if (last) begin
            tot  = (m_sum > 65535) ? 65535 : m_sum;
            m_pc = m_pc + 1;
            m_bc = m_bc + tot;
            if ((tot != int'(m_user[15:0])) || (m_sum > 65535))
                m_le = (m_le < 65535) ? m_le + 1 : 65535;
            if (m_serr)
                m_se = (m_se < 65535) ? m_se + 1 : 65535;
            m_ll  = tot[15:0];
            m_src = m_user[23:16];
            m_dst = m_user[31:24];
            done  = 1;
        end
    endtask

    task automatic send_beat(input logic [31:0] strb, input bit last,
                             input logic [31:0] user, input bit do_clr,
                             input bit gaps);
        bit done, rdy, cl, cmp;
        if (gaps && $urandom_range(3) == 0) begin
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(posedge axi_aclk); #1;
            end
        end
        s_axis_tvalid = 1'b1;
        s_axis_tstrb  = strb;
        s_axis_tlast  = last;
        s_axis_tuser  = {$urandom, $urandom, $urandom, user};
        s_axis_tdata  = {8{$urandom}};
        clear         = do_clr;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge axi_aclk);
            rdy = s_axis_tready;
            cl  = clear;
            @(posedge axi_aclk); #1;
            clear = 1'b0;
            cmp   = 0;
            if (rdy) begin
                model_beat(strb, last, user, cmp);
                done = 1;
            end
            if (cl) begin
                model_clear();
                check_zero("clear");
            end
            if (cmp) begin
                exp_t e;
                e.pc = m_pc; e.bc = m_bc;
                e.le = m_le[15:0]; e.se = m_se[15:0];
                e.ll = m_ll; e.src = m_src; e.dst = m_dst;
                sbq.push_back(e);
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Sends the beats queued in bq; later beats carry garbage tuser.
    task automatic send_pkt(input logic [31:0] user, input int clr_at,
                            input bit gaps);
        int nb;
        nb = bq.size();
        for (int i = 0; i < nb; i++) begin
            send_beat(bq[i], i == nb - 1, (i == 0) ? user : $urandom,
                      i == clr_at, gaps);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        bq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge axi_aclk); #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        model_clear();
        check_zero("pclr");
    endtask

    task automatic do_reset();
        axi_resetn    = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clear         = 1'b0;
        mptr      = 0;
        exp_rdy   = 0;
        exp_inpkt = 0;
        m_first   = 1;
        model_clear();
        #1;
        check_zero("rst");
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_done", {31'd0, pkt_done}, 32'd0);
        chk("rst_inpkt", {31'd0, in_pkt}, 32'd0);
        idle(2);
        axi_resetn = 1'b1;
    endtask

    initial begin
        int nb, n, kind;
        logic [31:0] u;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        ready_pattern = 8'hFF;
        do_reset();
        idle(2);

        // two full beats, 64 bytes, ports 1 -> 4
        bq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        send_pkt({8'h04, 8'h01, 16'd64}, -1, 0);
        idle(3);

        // 65 bytes, then a 4-byte single beat
        bq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        send_pkt({8'h10, 8'h20, 16'd65}, -1, 0);
        bq = '{32'h0000_000F};
        send_pkt({8'h03, 8'h02, 16'd4}, -1, 0);
        idle(2);

        // length mismatch, then two bad strobes in one packet
        bq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        send_pkt({8'h00, 8'h00, 16'd100}, -1, 0);
        bq = '{32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_0000};
        send_pkt({8'h05, 8'h06, 16'd80}, -1, 0);
        idle(2);

        // alternating backpressure with tvalid held high
        ready_pattern = 8'b0101_0101;
        bq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        send_pkt({8'h07, 8'h08, 16'd128}, -1, 0);
        idle(4);
        ready_pattern = 8'hFF;
        idle(2);

        // clear mid-packet after two earlier packets
        bq = '{32'hFFFF_FFFF};
        send_pkt({8'h01, 8'h01, 16'd32}, -1, 0);
        bq = '{32'hFFFF_FFFF};
        send_pkt({8'h01, 8'h01, 16'd32}, -1, 0);
        bq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        send_pkt({8'h0A, 8'h0B, 16'd96}, 1, 0);
        idle(2);
        // clear on the completion edge
        bq = '{32'h0000_00FF};
        send_pkt({8'h0C, 8'h0D, 16'd8}, 0, 0);
        idle(2);

        // reset abandons an in-flight packet
        send_beat(32'hFFFF_FFFF, 0, {8'h09, 8'h09, 16'd96}, 0, 0);
        send_beat(32'hFFFF_FFFF, 0, 32'h0, 0, 0);
        do_reset();
        bq = '{32'hFFFF_FFFF};
        send_pkt({8'h0E, 8'h0F, 16'd32}, -1, 0);
        idle(3);

        // randomized traffic
        for (int p = 0; p < 60; p++) begin
            ready_pattern = 8'($urandom) | (8'd1 << $urandom_range(7));
            nb   = $urandom_range(1, 4);
            n    = $urandom_range(1, 32);
            kind = $urandom_range(5);
            for (int i = 0; i < nb - 1; i++) bq.push_back(32'hFFFF_FFFF);
            bq.push_back(mask(n));
            if (kind == 1 && nb > 1) bq[0] = 32'h7FFF_FFFF;
            if (kind == 2) bq[nb - 1] = 32'h0000_0005;
            if (kind == 3) bq[nb - 1] = 32'h0;
            u = {8'($urandom), 8'($urandom), 16'((nb - 1) * 32 + n)};
            if (kind == 4) u[15:0] = u[15:0] + 16'd1;
            send_pkt(u, ($urandom_range(9) == 0) ? nb - 1 : -1, 1);
            if ($urandom_range(15) == 0) pulse_clear();
        end
        idle(5);
        chk("sb_drain", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
